// File: rtl/isa_load_ctrl.sv
// rtl/isa_load_ctrl.sv - ISA instruction-memory load sequencer and A/B write arbiter
//
// Purpose: arbitrates the host bulk loader (A) and the debug patch port (B) onto
// the single imem write port, counts in-range words against the requested load
// length, flags bad addresses, and holds the CPU in reset until the load is done.
//
// Optional feature macro: ISA_CHECKSUM_EN (running XOR checksum of loaded words).
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   load_start_i, load_len_i          start pulse and expected in-range word count
//   a_valid_i/a_ready_o/a_data_i/a_addr_i   requester A (host loader)
//   b_valid_i/b_ready_o/b_data_i/b_addr_i   requester B (debug patch)
//   isa_wren_o/isa_data_o/isa_addr_o  registered imem write port
//   cpu_hold_o                        1 = CPU held in reset
//   load_done_o                       1-cycle pulse, coincident with the final write
//   err_o                             sticky address error
//   checksum_o                        load checksum (0 when feature disabled)
module isa_load_ctrl #(
    parameter int                DATA_W    = 128,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH_W   = 12,
    parameter logic [ADDR_W-1:0] IMEM_BASE = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_start_i,
    input  logic [DEPTH_W-1:0] load_len_i,
    input  logic               a_valid_i,
    output logic               a_ready_o,
    input  logic [DATA_W-1:0]  a_data_i,
    input  logic [ADDR_W-1:0]  a_addr_i,
    input  logic               b_valid_i,
    output logic               b_ready_o,
    input  logic [DATA_W-1:0]  b_data_i,
    input  logic [ADDR_W-1:0]  b_addr_i,
    output logic               isa_wren_o,
    output logic [DATA_W-1:0]  isa_data_o,
    output logic [ADDR_W-1:0]  isa_addr_o,
    output logic               cpu_hold_o,
    output logic               load_done_o,
    output logic               err_o,
    output logic [31:0]        checksum_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    // One extra bit so a full-depth length never wraps the counter.
    logic [DEPTH_W:0]    r_count;
    logic [DEPTH_W:0]    r_len;
    logic                r_last_a;      // 1 = A was granted most recently
    logic                r_wren;
    logic [DATA_W-1:0]   r_data;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_hold;
    logic                r_done;
    logic                r_err;

    logic                w_a_ready;
    logic                w_b_ready;
    logic                w_xfer;
    logic                w_xfer_a;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic [ADDR_W-1:0]   w_off;
    logic [ADDR_W-1:0]   w_off_hi;
    logic                w_in_range;
    logic                w_wr;
    logic                w_start;
    logic                w_len_zero;
    logic                w_load_last;
    logic                w_done;
    logic [DEPTH_W:0]    w_count_inc;

    assign w_count_inc = r_count + 1'b1;
    assign w_len_zero  = (load_len_i == '0);

    always_comb begin
        w_a_ready   = 1'b0;
        w_b_ready   = 1'b0;
        w_state_nxt = r_state;

        case (r_state)
            S_LOAD: begin
                // Round-robin: A wins unless B is also waiting and A went last.
                if (a_valid_i && (!b_valid_i || !r_last_a))
                    w_a_ready = 1'b1;
                else if (b_valid_i)
                    w_b_ready = 1'b1;
            end
            S_RUN:   w_b_ready = b_valid_i;
            default: ;
        endcase

        w_xfer_a   = a_valid_i & w_a_ready;
        w_xfer     = w_xfer_a | (b_valid_i & w_b_ready);
        w_sel_addr = w_xfer_a ? a_addr_i : b_addr_i;
        w_sel_data = w_xfer_a ? a_data_i : b_data_i;

        // Offset above base must fit in 16 * 2^DEPTH_W bytes.
        w_off      = w_sel_addr - IMEM_BASE;
        w_off_hi   = w_off >> (DEPTH_W + 4);
        w_in_range = (w_sel_addr[3:0] == 4'h0) && (w_sel_addr >= IMEM_BASE) &&
                     (w_off_hi == '0);
        w_wr       = w_xfer & w_in_range;

        w_start     = load_start_i && (r_state != S_LOAD);
        w_load_last = (r_state == S_LOAD) && w_wr && (w_count_inc == r_len);
        w_done      = (w_start && w_len_zero) || w_load_last;

        if (w_start)
            w_state_nxt = w_len_zero ? S_RUN : S_LOAD;
        else if (w_load_last)
            w_state_nxt = S_RUN;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count  <= '0;
            r_len    <= '0;
            r_last_a <= 1'b0;
            r_wren   <= 1'b0;
            r_data   <= '0;
            r_addr   <= '0;
            r_hold   <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_wren <= w_wr;
            if (w_wr) begin
                r_data <= w_sel_data;
                r_addr <= w_sel_addr;
            end
            r_done <= w_done;

            if (w_xfer)
                r_last_a <= w_xfer_a;

            if (w_start) begin
                r_count  <= '0;
                r_len    <= {1'b0, load_len_i};
                r_last_a <= 1'b0;
            end else if (r_state == S_LOAD && w_wr) begin
                r_count  <= w_count_inc;
            end

            if (w_start)
                r_hold <= !w_len_zero;
            else if (w_done)
                r_hold <= 1'b0;

            // A bad address in the same cycle as a restart still gets flagged.
            if (w_xfer && !w_in_range)
                r_err <= 1'b1;
            else if (w_start)
                r_err <= 1'b0;
        end
    end

    assign a_ready_o   = w_a_ready;
    assign b_ready_o   = w_b_ready;
    assign isa_wren_o  = r_wren;
    assign isa_data_o  = r_data;
    assign isa_addr_o  = r_addr;
    assign cpu_hold_o  = r_hold;
    assign load_done_o = r_done;
    assign err_o       = r_err;

`ifdef ISA_CHECKSUM_EN
    logic [31:0] r_checksum;
    logic [31:0] w_lane_xor;

    always_comb begin
        w_lane_xor = '0;
        for (int i = 0; i < DATA_W / 32; i++)
            w_lane_xor = w_lane_xor ^ w_sel_data[i*32 +: 32];
    end

    // Only LOAD-state writes contribute, so the value freezes once RUN is reached.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_checksum <= '0;
        else if (w_start)
            r_checksum <= '0;
        else if (r_state == S_LOAD && w_wr)
            r_checksum <= r_checksum ^ w_lane_xor;
    end

    assign checksum_o = r_checksum;
`else
    assign checksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_isa_load_ctrl.sv
// tb/tb_isa_load_ctrl.sv - directed self-checking bench for isa_load_ctrl
module tb_isa_load_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_start = 1'b0;
    logic [11:0]  load_len = '0;
    logic         a_valid = 1'b0;
    logic         a_ready;
    logic [127:0] a_data = '0;
    logic [31:0]  a_addr = '0;
    logic         b_valid = 1'b0;
    logic         b_ready;
    logic [127:0] b_data = '0;
    logic [31:0]  b_addr = '0;
    logic         wren;
    logic [127:0] isa_data;
    logic [31:0]  isa_addr;
    logic         cpu_hold;
    logic         load_done;
    logic         err;
    logic [31:0]  checksum;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    isa_load_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_start_i (load_start),
        .load_len_i   (load_len),
        .a_valid_i    (a_valid),
        .a_ready_o    (a_ready),
        .a_data_i     (a_data),
        .a_addr_i     (a_addr),
        .b_valid_i    (b_valid),
        .b_ready_o    (b_ready),
        .b_data_i     (b_data),
        .b_addr_i     (b_addr),
        .isa_wren_o   (wren),
        .isa_data_o   (isa_data),
        .isa_addr_o   (isa_addr),
        .cpu_hold_o   (cpu_hold),
        .load_done_o  (load_done),
        .err_o        (err),
        .checksum_o   (checksum)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        a_valid = 1'b0; b_valid = 1'b0; load_start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_load(input logic [11:0] len);
        load_len = len;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1;
        tick();
        checks++;
        if ({wren, load_done, err, a_ready, b_ready, cpu_hold} !== 6'b000001) begin
            failures++;
            $display("FAIL reset_outputs: got wren/done/err/ardy/brdy/hold=%b want 000001",
                     {wren, load_done, err, a_ready, b_ready, cpu_hold});
        end
        checks++;
        if (checksum !== 32'h0 || isa_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_regs: got checksum=%h addr=%h want 0 0", checksum, isa_addr);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready: got a=%b b=%b want 0 0", a_ready, b_ready);
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        do_reset();
        start_load(12'd4);
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_addr = 32'(i * 16);
            a_data = {96'h0, 32'h100 + 32'(i)};
            #1;
            checks++;
            if (a_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d]: got %b want 1", i, a_ready);
            end
            tick();
            checks++;
            if (wren !== 1'b1 || isa_addr !== 32'(i * 16) ||
                isa_data !== {96'h0, 32'h100 + 32'(i)} ||
                load_done !== (i == 3) || cpu_hold !== (i != 3)) begin
                failures++;
                $display("FAIL b2b_write[%0d]: got wren=%b addr=%h data=%h done=%b hold=%b want 1 %h %h %b %b",
                         i, wren, isa_addr, isa_data[31:0], load_done, cpu_hold,
                         i * 16, 32'h100 + 32'(i), i == 3, i != 3);
            end
        end
        a_valid = 1'b0;
        tick();
        checks++;
        if (wren !== 1'b0 || load_done !== 1'b0 || cpu_hold !== 1'b0 || isa_addr !== 32'h30) begin
            failures++;
            $display("FAIL b2b_after: got wren=%b done=%b hold=%b addr=%h want 0 0 0 30",
                     wren, load_done, cpu_hold, isa_addr);
        end
    endtask

    task automatic test_round_robin;
        int na;
        int nb;
        logic exp_a;
        logic [31:0] exp_addr;
        na = 0; nb = 0;
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1;
        start_load(12'd8);
        for (int i = 0; i < 8; i++) begin
            a_addr = 32'(na * 32);
            b_addr = 32'(nb * 32 + 16);
            exp_a = (i % 2 == 0);
            exp_addr = exp_a ? a_addr : b_addr;
            #1;
            checks++;
            if (a_ready !== exp_a || b_ready !== !exp_a) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got a=%b b=%b want %b %b", i, a_ready, b_ready, exp_a, !exp_a);
            end
            tick();
            checks++;
            if (wren !== 1'b1 || isa_addr !== exp_addr || load_done !== (i == 7)) begin
                failures++;
                $display("FAIL rr_write[%0d]: got wren=%b addr=%h done=%b want 1 %h %b",
                         i, wren, isa_addr, load_done, exp_addr, i == 7);
            end
            if (exp_a) na++; else nb++;
        end
        b_valid = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b0 || cpu_hold !== 1'b0) begin
            failures++;
            $display("FAIL rr_run_a_blocked: got a_ready=%b hold=%b want 0 0", a_ready, cpu_hold);
        end
        a_valid = 1'b0;
        tick();
    endtask

    task automatic test_range_err;
        do_reset();
        start_load(12'd2);
        a_valid = 1'b1;
        a_addr = 32'h0001_0000;
        tick();
        checks++;
        if (wren !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL range_high: got wren=%b err=%b want 0 1", wren, err);
        end
        a_addr = 32'h8;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL range_misalign_ready: got %b want 1", a_ready);
        end
        tick();
        checks++;
        if (wren !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL range_misalign: got wren=%b err=%b want 0 1", wren, err);
        end
        a_addr = 32'h40;
        tick();
        checks++;
        if (wren !== 1'b1 || isa_addr !== 32'h40 || load_done !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL range_ok_write: got wren=%b addr=%h done=%b err=%b want 1 40 0 1",
                     wren, isa_addr, load_done, err);
        end
        a_addr = 32'h50;
        tick();
        checks++;
        if (wren !== 1'b1 || load_done !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL range_count: got wren=%b done=%b err=%b want 1 1 1", wren, load_done, err);
        end
        a_valid = 1'b0;
        tick();
    endtask

    task automatic test_len_zero;
        do_reset();
        start_load(12'd0);
        checks++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || wren !== 1'b0) begin
            failures++;
            $display("FAIL len0_done: got done=%b hold=%b wren=%b want 1 0 0", load_done, cpu_hold, wren);
        end
        tick();
        checks++;
        if (load_done !== 1'b0 || cpu_hold !== 1'b0) begin
            failures++;
            $display("FAIL len0_after: got done=%b hold=%b want 0 0", load_done, cpu_hold);
        end
    endtask

    task automatic test_reset_mid_load;
        do_reset();
        start_load(12'd4);
        a_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_addr = 32'(i * 16);
            tick();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (wren !== 1'b0 || a_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL midrst: got wren=%b a_ready=%b hold=%b want 0 0 1", wren, a_ready, cpu_hold);
        end
        #1;
        rst = 1'b0;
        a_valid = 1'b0;
        tick();
        start_load(12'd4);
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_addr = 32'h200 + 32'(i * 16);
            tick();
            checks++;
            if (wren !== 1'b1 || isa_addr !== 32'h200 + 32'(i * 16) || load_done !== (i == 3)) begin
                failures++;
                $display("FAIL midrst_reload[%0d]: got wren=%b addr=%h done=%b want 1 %h %b",
                         i, wren, isa_addr, load_done, 32'h200 + 32'(i * 16), i == 3);
            end
        end
        a_valid = 1'b0;
        tick();
    endtask

    task automatic test_checksum;
        logic [31:0] exp_sum;
`ifdef ISA_CHECKSUM_EN
        exp_sum = 32'h0000_000B;
`else
        exp_sum = 32'h0;
`endif
        do_reset();
        start_load(12'd2);
        a_valid = 1'b1;
        a_addr = 32'h0;
        a_data = {32'h1, 32'h2, 32'h3, 32'h4};
        tick();
        a_addr = 32'h10;
        a_data = {32'hF, 32'h0, 32'h0, 32'h0};
        tick();
        a_valid = 1'b0;
        checks++;
        if (load_done !== 1'b1 || checksum !== exp_sum) begin
            failures++;
            $display("FAIL cksum_done: got done=%b checksum=%h want 1 %h", load_done, checksum, exp_sum);
        end
        b_valid = 1'b1;
        b_addr = 32'h100;
        b_data = {128{1'b1}};
        #1;
        checks++;
        if (b_ready !== 1'b1) begin
            failures++;
            $display("FAIL run_patch_ready: got %b want 1", b_ready);
        end
        tick();
        b_valid = 1'b0;
        checks++;
        if (wren !== 1'b1 || isa_addr !== 32'h100 || checksum !== exp_sum || cpu_hold !== 1'b0) begin
            failures++;
            $display("FAIL run_patch: got wren=%b addr=%h checksum=%h hold=%b want 1 100 %h 0",
                     wren, isa_addr, checksum, cpu_hold, exp_sum);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_round_robin();
        test_range_err();
        test_len_zero();
        test_reset_mid_load();
        test_checksum();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
